seq_mult_ctrl: RTL and testbench

Sequential shift-add multiplier that pairs a load/enable/clear control FSM with its own operand, accumulator and step-counter registers. It accepts a one-cycle `start` request, sequences the datapath through load, WIDTH accumulate steps and completion, then presents a held `product` with a one-cycle `done` pulse. It is the standard arithmetic engine for the controller-driven datapaths in this design. It exports its `ld`/`en`/`dp_clr` strobes for observation and for chaining.

---
 rtl/seq_mult_ctrl.sv | 149 ++++++++++++++
 tb/tb_seq_mult_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: sequential shift-add multiplier with its own control FSM.
// A single start request loads the operands, runs WIDTH accumulate steps,
// then holds the product and pulses done for one cycle.
// ld/en/dp_clr are exported so surrounding datapaths can follow the sequence.
module seq_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               clr,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               ld,
    output logic               en,
    output logic               dp_clr
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CALC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   product_q, product_d;
    logic [PW-1:0]   step_sum_s;

    // Next-state selection; clr forces IDLE from any state and beats start.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LOAD: state_d = S_CALC;
                S_CALC: begin
                    if (count_q == LAST_STEP) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Accumulator value after the current CALC step (conditional add of mcand).
    always_comb begin
        if (mplier_q[0]) begin
            step_sum_s = acc_q + mcand_q;
        end else begin
            step_sum_s = acc_q;
        end
    end

    // Datapath next values: load, shift-add step, and the product capture
    // on the final step so product is already valid while done is high.
    always_comb begin
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;
        if (clr) begin
            mcand_d   = '0;
            mplier_d  = '0;
            acc_d     = '0;
            count_d   = '0;
            product_d = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    count_d  = '0;
                end
                S_CALC: begin
                    acc_d    = step_sum_s;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + CW'(1);
                    if (count_q == LAST_STEP) begin
                        product_d = step_sum_s;
                    end else begin
                        product_d = product_q;
                    end
                end
                default: begin
                    mcand_d = mcand_q;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    // Output strobes decoded from registered state; dp_clr also follows clr
    // in the same cycle so a chained datapath clears alongside this one.
    always_comb begin
        busy   = (state_q == S_LOAD) || (state_q == S_CALC);
        done   = (state_q == S_DONE);
        ld     = (state_q == S_LOAD);
        en     = (state_q == S_CALC);
        dp_clr = (state_q == S_LOAD) || clr;
    end

    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl (WIDTH=8): a cycle-phase reference
// model compared every cycle, plus directed operations with literal results.
module tb_seq_mult_ctrl;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          clr = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy, done, ld, en, dp_clr;
    logic [2*W-1:0] product;

    int n_tests = 0;
    int n_fail  = 0;

    seq_mult_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .clr(clr),
        .a(a), .b(b), .busy(busy), .done(done), .product(product),
        .ld(ld), .en(en), .dp_clr(dp_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ph counts cycles since the start was accepted
    // (0 idle, 1 load, 2..W+1 steps, W+2 done); result is plain a*b.
    int            ph = 0;
    logic [W-1:0]  ma = '0;
    logic [W-1:0]  mb = '0;
    logic [2*W-1:0] m_prod = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph     <= 0;
            m_prod <= '0;
        end else if (clr) begin
            ph     <= 0;
            m_prod <= '0;
        end else if (ph == 0) begin
            if (start) ph <= 1;
        end else if (ph == 1) begin
            ma <= a;
            mb <= b;
            ph <= 2;
        end else if (ph == W + 1) begin
            ph     <= W + 2;
            m_prod <= 16'(ma) * 16'(mb);
        end else if (ph == W + 2) begin
            ph <= 0;
        end else begin
            ph <= ph + 1;
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        chk("m_busy",    32'(busy),    32'(ph >= 1 && ph <= W + 1));
        chk("m_done",    32'(done),    32'(ph == W + 2));
        chk("m_ld",      32'(ld),      32'(ph == 1));
        chk("m_en",      32'(en),      32'(ph >= 2 && ph <= W + 1));
        chk("m_dp_clr",  32'(dp_clr),  32'(ph == 1 || clr));
        chk("m_product", 32'(product), 32'(m_prod));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start an operation, optionally pulse start again in cycle ign_cyc,
    // and check latency, busy coverage and the literal product.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [2*W-1:0] exp, input string nm, input int ign_cyc);
        int lat;
        a = x; b = y; start = 1'b1;
        step();
        start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            if (n == 2) begin a = 8'($urandom); b = 8'($urandom); end
            start = (n == ign_cyc);
            if (done) begin lat = n; break; end
            chk({nm, "_busy"}, 32'(busy), 32'd1);
            step();
        end
        start = 1'b0;
        chk({nm, "_latency"}, 32'(lat), 32'd10);
        chk({nm, "_product"}, 32'(product), 32'(exp));
        step();
        chk({nm, "_done_once"}, 32'(done), 32'd0);
        chk({nm, "_hold"}, 32'(product), 32'(exp));
    endtask

    initial begin
        int last_done, ndone;

        // Reset state
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        step(); step();
        reset_n = 1'b1;
        step(); step();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ld", 32'(ld), 32'd0);

        // Basic and extreme operands
        run_op(8'd13,  8'd11,  16'd143,   "basic", 0);
        run_op(8'd255, 8'd255, 16'd65025, "max",   0);
        run_op(8'd0,   8'd77,  16'd0,     "zero",  0);
        run_op(8'd1,   8'd200, 16'd200,   "one",   0);
        run_op(8'd128, 8'd2,   16'd256,   "msb",   0);

        // Abort with clr in the 4th step cycle
        a = 8'd50; b = 8'd50; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        clr = 1'b1;
        #1;
        chk("abort_dp_clr", 32'(dp_clr), 32'd1);
        step();
        clr = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_product", 32'(product), 32'd0);
        for (int n = 0; n < 12; n++) begin
            chk("abort_no_done", 32'(done), 32'd0);
            step();
        end
        run_op(8'd6, 8'd7, 16'd42, "after_abort", 0);

        // start during the step phase is ignored
        run_op(8'd13, 8'd11, 16'd143, "ign", 4);
        for (int n = 0; n < 12; n++) begin
            chk("ign_no_second", 32'(busy | done), 32'd0);
            step();
        end

        // clr beats start in IDLE
        start = 1'b1; clr = 1'b1;
        step();
        start = 1'b0; clr = 1'b0;
        chk("prio_ld", 32'(ld), 32'd0);
        chk("prio_busy", 32'(busy), 32'd0);
        step();
        chk("prio_ld2", 32'(ld), 32'd0);

        // Streaming: start held high
        a = 8'd3; b = 8'd5; start = 1'b1;
        step();
        last_done = 0; ndone = 0;
        for (int n = 1; n <= 40; n++) begin
            if (done) begin
                ndone++;
                chk("stream_product", 32'(product), 32'd15);
                if (last_done != 0) chk("stream_period", 32'(n - last_done), 32'd11);
                last_done = n;
            end
            step();
        end
        start = 1'b0;
        chk("stream_count", 32'(ndone), 32'd3);
        repeat (12) step();

        // Asynchronous reset mid-step of 200x3
        a = 8'd200; b = 8'd3; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_ld", 32'(ld), 32'd0);
        chk("arst_en", 32'(en), 32'd0);
        chk("arst_dp_clr", 32'(dp_clr), 32'd0);
        chk("arst_product", 32'(product), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_product", 32'(product), 32'd0);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
